// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern-detection run controller.
package seq_det_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 16;
  localparam int LEN_W_DEF = $clog2(PAT_W_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic [PAT_W_DEF-1:0] pattern;
    logic [LEN_W_DEF-1:0] len;
    logic                 overlap;
    logic [WIN_W_DEF-1:0] window;
  } cfg_t;

  // Power-on configuration: single-bit pattern '0', overlapping, unbounded window.
  localparam cfg_t CFG_RESET = '{pattern: '0, len: LEN_W_DEF'(1), overlap: 1'b1, window: '0};

  function automatic logic len_legal(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_pattern_matcher.sv
// History shift register, fill tracking and length-masked compare.
// hit_o is combinational on the history as it will be after the current shift.
module seq_pattern_matcher #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             shift_en_i,
  input  logic             din_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic             overlap_i,
  output logic             hit_o
);

  logic [PAT_W-1:0] hist_q, hist_d, hist_sh, mask;
  logic [LEN_W-1:0] fill_q, fill_d, fill_inc;

  always_comb begin
    hist_sh  = PAT_W'({hist_q, din_i});
    fill_inc = (fill_q >= len_i) ? len_i : fill_q + LEN_W'(1);
    mask     = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_i));
    end
    hit_o = shift_en_i && (fill_inc == len_i) && (((hist_sh ^ pattern_i) & mask) == '0);
  end

  // Non-overlap mode restarts the fill so a new match needs len fresh bits.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en_i) begin
      hist_d = hist_sh;
      fill_d = (hit_o && !overlap_i) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: config handshake, IDLE/RUN/DONE sequencing, bit and match
// counting around a programmable serial pattern matcher.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [WIN_W-1:0] cfg_window,
  output logic             cfg_err,
  input  logic             start,
  input  logic             abort,
  input  logic             din_valid,
  input  logic             din,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             done
);

  ctrl_state_t state_q, state_d;

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [WIN_W-1:0] win_q;

  logic [WIN_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic             cfg_err_q, match_q, done_q;

  logic cfg_xfer, cfg_ok, run_start, accept, win_end, hit;

  assign cfg_ready = (state_q == IDLE);
  assign cfg_xfer  = cfg_valid && cfg_ready;
  assign cfg_ok    = len_legal(int'(cfg_len), PAT_W);
  assign run_start = start && (state_q == IDLE);
  // Abort takes priority over any bit offered in the same cycle.
  assign accept    = (state_q == RUN) && din_valid && !abort;
  assign win_end   = accept && (win_q != '0) && ((bcnt_q + WIN_W'(1)) == win_q);

  seq_pattern_matcher #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_matcher (
    .clk        (clk),
    .rst        (reset),
    .clr_i      (run_start),
    .shift_en_i (accept),
    .din_i      (din),
    .len_i      (len_q),
    .pattern_i  (pat_q),
    .overlap_i  (ovl_q),
    .hit_o      (hit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (abort)        state_d = IDLE;
        else if (win_end) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (run_start) begin
      bcnt_d = '0;
      mcnt_d = '0;
    end else if (accept) begin
      bcnt_d = bcnt_q + WIN_W'(1);
      if (hit && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pat_q     <= PAT_W'(CFG_RESET.pattern);
      len_q     <= LEN_W'(CFG_RESET.len);
      ovl_q     <= CFG_RESET.overlap;
      win_q     <= WIN_W'(CFG_RESET.window);
      bcnt_q    <= '0;
      mcnt_q    <= '0;
      cfg_err_q <= 1'b0;
      match_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // A config offered alongside start lands here first, so the run sees it.
      if (cfg_xfer && cfg_ok) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
        win_q <= cfg_window;
      end
      bcnt_q    <= bcnt_d;
      mcnt_q    <= mcnt_d;
      cfg_err_q <= cfg_xfer && !cfg_ok;
      match_q   <= accept && hit;
      done_q    <= win_end;
    end
  end

  assign busy        = (state_q == RUN) || (state_q == DONE);
  assign cfg_err     = cfg_err_q;
  assign match       = match_q;
  assign match_count = mcnt_q;
  assign done        = done_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: vector table, hand-written corner sequences and
// randomized runs against a stream-level reference model.
module tb_seq_detect_ctrl;
  import seq_det_pkg::*;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int WIN_W = 16;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_valid, cfg_ready, cfg_overlap, cfg_err;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [WIN_W-1:0] cfg_window;
  logic             start, abort, din_valid, din;
  logic             busy, match, done;
  logic [CNT_W-1:0] match_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W),
    .WIN_W (WIN_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_window  (cfg_window),
    .cfg_err     (cfg_err),
    .start       (start),
    .abort       (abort),
    .din_valid   (din_valid),
    .din         (din),
    .busy        (busy),
    .match       (match),
    .match_count (match_count),
    .done        (done)
  );

  typedef struct {
    cfg_t        c;
    logic [15:0] bits;   // bits[i] is the i-th bit delivered
    int          n;
    logic [15:0] mmask;  // mmask[i]: match expected after bit i
    int          gap;
    logic [7:0]  cnt;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];

  // Reference model state: every accepted bit of the run, plus the index from
  // which a fresh match may begin.
  bit stream [$];
  int fresh;

  function automatic bit model_hit(input logic [7:0] p, input int l);
    if (stream.size() - fresh < l) return 1'b0;
    for (int k = 0; k < l; k++)
      if (stream[stream.size() - l + k] != p[l-1-k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] p, input int l, input logic ov, input int w,
                        input logic exp_err);
    cfg_valid   = 1'b1;
    cfg_pattern = p;
    cfg_len     = LEN_W'(l);
    cfg_overlap = ov;
    cfg_window  = WIN_W'(w);
    step;
    cfg_valid = 1'b0;
    chk("cfg_err after cfg", cfg_err, exp_err);
  endtask

  task automatic do_start;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("busy after start", busy, 1);
    chk("count cleared at start", match_count, 0);
  endtask

  task automatic send_bit(input logic b, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      din_valid = 1'b0;
      din       = ~b;
      step;
    end
    din_valid = 1'b1;
    din       = b;
    step;
    din_valid = 1'b0;
  endtask

  task automatic do_abort;
    abort = 1'b1;
    step;
    abort = 1'b0;
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rp;
    int         rl, rw, phase, acc, cnt;
    logic       rov, vld, b, ab, exp_m, exp_d;

    reset = 1'b1; cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    cfg_window = '0; start = 0; abort = 0; din_valid = 0; din = 0;

    vec[0] = '{'{8'h1B, 4'd5, 1'b1, 16'd0}, 16'h00DB, 8, 16'h0090, 0, 8'd2};
    vec[1] = '{'{8'h1B, 4'd5, 1'b0, 16'd0}, 16'h00DB, 8, 16'h0010, 0, 8'd1};
    vec[2] = '{'{8'h1B, 4'd5, 1'b1, 16'd8}, 16'h00DB, 8, 16'h0090, 0, 8'd2};
    vec[3] = '{'{8'h1B, 4'd5, 1'b1, 16'd0}, 16'h00DB, 8, 16'h0090, 2, 8'd2};
    vec[4] = '{'{8'h1B, 4'd5, 1'b0, 16'd0}, 16'h00DB, 8, 16'h0010, 1, 8'd1};
    vec[5] = '{'{8'h04, 4'd3, 1'b1, 16'd0}, 16'h0009, 6, 16'h0024, 0, 8'd2};
    vec[6] = '{'{8'h05, 4'd3, 1'b0, 16'd5}, 16'h0015, 5, 16'h0004, 0, 8'd1};
    vec[7] = '{'{8'h05, 4'd3, 1'b1, 16'd0}, 16'h0015, 5, 16'h0014, 0, 8'd2};
    vec[8] = '{'{8'hA5, 4'd8, 1'b1, 16'd0}, 16'h014A, 9, 16'h0100, 0, 8'd1};
    vec[9] = '{'{8'h04, 4'd3, 1'b0, 16'd6}, 16'h0009, 6, 16'h0024, 1, 8'd2};

    // Reset state
    step; step;
    chk("reset cfg_ready", cfg_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset match", match, 0);
    chk("reset done", done, 0);
    chk("reset cfg_err", cfg_err, 0);
    chk("reset match_count", match_count, 0);
    reset = 1'b0;
    step;

    // Power-on config: pattern '0', len 1
    do_start;
    send_bit(1'b1, 0); chk("default cfg bit1", match, 0);
    send_bit(1'b0, 0); chk("default cfg bit0", match, 1);
    chk("default cfg count", match_count, 1);
    do_abort;
    chk("default abort busy", busy, 0);

    // Vector table
    for (int v = 0; v < NV; v++) begin
      do_cfg(vec[v].c.pattern, int'(vec[v].c.len), vec[v].c.overlap, int'(vec[v].c.window), 1'b0);
      do_start;
      for (int i = 0; i < vec[v].n; i++) begin
        send_bit(vec[v].bits[i], vec[v].gap);
        chk($sformatf("v%0d match bit%0d", v, i), match, vec[v].mmask[i]);
        chk($sformatf("v%0d done bit%0d", v, i), done,
            (vec[v].c.window != 0) && (i == vec[v].n - 1));
      end
      chk($sformatf("v%0d count", v), match_count, vec[v].cnt);
      if (vec[v].c.window != 0) begin
        chk($sformatf("v%0d busy in DONE", v), busy, 1);
        step;
        chk($sformatf("v%0d busy after DONE", v), busy, 0);
        chk($sformatf("v%0d ready after DONE", v), cfg_ready, 1);
        chk($sformatf("v%0d done one cycle", v), done, 0);
      end else begin
        do_abort;
        chk($sformatf("v%0d abort busy", v), busy, 0);
        chk($sformatf("v%0d abort done", v), done, 0);
        chk($sformatf("v%0d abort count held", v), match_count, vec[v].cnt);
      end
    end

    // Illegal configs keep the stored one
    do_cfg(8'h1B, 5, 1'b1, 0, 1'b0);
    do_cfg(8'hFF, 0, 1'b1, 0, 1'b1);
    step;
    chk("cfg_err one cycle", cfg_err, 0);
    do_cfg(8'hFF, 9, 1'b1, 0, 1'b1);
    do_start;
    send_bit(1'b1, 0); chk("kept cfg b0", match, 0);
    send_bit(1'b1, 0); chk("kept cfg b1", match, 0);
    // Config offered during RUN is ignored
    cfg_valid = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd0;
    send_bit(1'b0, 0);
    chk("run cfg ready", cfg_ready, 0);
    step;
    chk("run cfg no err", cfg_err, 0);
    cfg_pattern = 8'h01; cfg_len = 4'd1;
    send_bit(1'b1, 0); chk("run cfg ignored b3", match, 0);
    cfg_valid = 1'b0;
    send_bit(1'b1, 0); chk("kept cfg b4", match, 1);
    chk("kept cfg count", match_count, 1);
    do_abort;

    // start together with a legal config: run uses the new one
    cfg_valid = 1'b1; cfg_pattern = 8'h02; cfg_len = 4'd3; cfg_overlap = 1'b1;
    cfg_window = '0; start = 1'b1;
    step;
    cfg_valid = 1'b0; start = 1'b0;
    chk("start+cfg err", cfg_err, 0);
    chk("start+cfg busy", busy, 1);
    send_bit(1'b0, 0); send_bit(1'b1, 0);
    send_bit(1'b0, 0); chk("start+cfg match", match, 1);
    do_abort;
    // start together with an illegal config: previous config used
    cfg_valid = 1'b1; cfg_pattern = 8'h07; cfg_len = 4'd0; start = 1'b1;
    step;
    cfg_valid = 1'b0; start = 1'b0;
    chk("start+bad cfg err", cfg_err, 1);
    chk("start+bad cfg busy", busy, 1);
    send_bit(1'b1, 0); send_bit(1'b1, 0);
    send_bit(1'b1, 0); chk("start+bad cfg 111", match, 0);
    send_bit(1'b0, 0); send_bit(1'b1, 0);
    send_bit(1'b0, 0); chk("start+bad cfg 010", match, 1);
    do_abort;

    // Saturation and abort
    do_cfg(8'h01, 1, 1'b1, 0, 1'b0);
    do_start;
    for (int i = 0; i < 300; i++) send_bit(1'b1, 0);
    chk("sat match", match, 1);
    chk("sat count", match_count, 255);
    abort = 1'b1; din_valid = 1'b1; din = 1'b1;
    step;
    abort = 1'b0; din_valid = 1'b0;
    chk("sat abort busy", busy, 0);
    chk("sat abort match", match, 0);
    chk("sat abort done", done, 0);
    chk("sat abort count", match_count, 255);

    // Abort beats a window-completing bit
    do_cfg(8'h01, 1, 1'b1, 3, 1'b0);
    do_start;
    send_bit(1'b1, 0); send_bit(1'b1, 0);
    abort = 1'b1; din_valid = 1'b1; din = 1'b1;
    step;
    abort = 1'b0; din_valid = 1'b0;
    chk("abort vs window done", done, 0);
    chk("abort vs window match", match, 0);
    chk("abort vs window count", match_count, 2);
    chk("abort vs window busy", busy, 0);

    // Reset mid-run
    do_cfg(8'h1B, 5, 1'b1, 0, 1'b0);
    do_start;
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    chk("pre-reset match", match, 1);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", busy, 0);
    chk("async reset match", match, 0);
    chk("async reset count", match_count, 0);
    chk("async reset done", done, 0);
    chk("async reset ready", cfg_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    send_bit(1'b1, 0);
    chk("no run without start", busy, 0);
    do_cfg(8'h1B, 5, 1'b1, 0, 1'b0);
    do_start;
    send_bit(1'b1, 0); chk("post-reset b0", match, 0);
    send_bit(1'b0, 0); chk("post-reset b1", match, 0);
    send_bit(1'b1, 0); chk("post-reset b2", match, 0);
    send_bit(1'b1, 0); chk("post-reset b3", match, 0);
    chk("post-reset count", match_count, 0);
    do_abort;

    // Randomized runs against the stream model
    for (int r = 0; r < 16; r++) begin
      rp  = 8'($urandom);
      rl  = (r % 4 == 3) ? $urandom_range(5, 8) : $urandom_range(1, 4);
      rov = 1'($urandom);
      rw  = ($urandom % 2 == 0) ? 0 : $urandom_range(4, 40);
      do_cfg(rp, rl, rov, rw, 1'b0);
      do_start;
      stream.delete();
      fresh = 0; acc = 0; cnt = 0; phase = 1;
      for (int cyc = 0; cyc < 400 && phase != 0; cyc++) begin
        vld = ($urandom % 4) != 0;
        b   = 1'($urandom);
        ab  = (rw == 0 && cyc >= 300) || ($urandom % 128 == 0);
        din_valid = vld; din = b; abort = ab;
        step;
        exp_m = 1'b0; exp_d = 1'b0;
        if (phase == 2) begin
          phase = 0;
        end else if (ab) begin
          phase = 0;
        end else if (vld) begin
          stream.push_back(b);
          acc++;
          if (model_hit(rp, rl)) begin
            exp_m = 1'b1;
            if (cnt < 255) cnt++;
            if (!rov) fresh = stream.size();
          end
          if (rw != 0 && acc == rw) begin
            exp_d = 1'b1;
            phase = 2;
          end
        end
        chk($sformatf("rnd%0d c%0d match", r, cyc), match, exp_m);
        chk($sformatf("rnd%0d c%0d done", r, cyc), done, exp_d);
        chk($sformatf("rnd%0d c%0d count", r, cyc), match_count, cnt);
        chk($sformatf("rnd%0d c%0d busy", r, cyc), busy, phase != 0);
      end
      din_valid = 1'b0; abort = 1'b0;
      step;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
